// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and ramp FSM state encoding for the PWM duty path.
package pwm_pkg;
    localparam int DW_DEF            = 8;
    localparam int PERIOD_CYCLES_DEF = 4096;
    localparam int MAX_DUTY_DEF      = 240;
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} ramp_state_e;
endpackage

// File: rtl/pwm_period_tick.sv
// pwm_period_tick: free-running period counter with a registered pulse on the last clock of each period.
module pwm_period_tick import pwm_pkg::*; #(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic period_tick
);
    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    assign cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign period_tick = tick_q;
    // tick is registered from the next count so it is high exactly while the counter sits at LAST
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews the PWM duty toward an accepted target by STEP once per period.
// Define PWM_DUTY_CLAMP_EN to limit accepted targets to MAX_DUTY.
module pwm_duty_ramp import pwm_pkg::*; #(
    parameter int DW            = DW_DEF,
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int STEP          = 1,
    parameter int MAX_DUTY      = MAX_DUTY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] tgt_duty,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    output logic [DW-1:0] duty_out,
    output logic          period_tick,
    output logic          busy
);
    localparam logic [DW-1:0] STEP_N = DW'(STEP);
    ramp_state_e   state_q;
    logic [DW-1:0] duty_q, tgt_q, tgt_d;
    logic          ready_q, busy_q;
    logic [DW:0]   up_diff, dn_diff;

    pwm_period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick)
    );

`ifdef PWM_DUTY_CLAMP_EN
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DUTY);
    assign tgt_d = (tgt_duty > MAX_D) ? MAX_D : tgt_duty;
`else
    logic unused_max;
    assign unused_max = ^MAX_DUTY;
    assign tgt_d      = tgt_duty;
`endif

    // one extra bit keeps the distance positive and the step comparison wrap-free
    assign up_diff   = {1'b0, tgt_q} - {1'b0, duty_q};
    assign dn_diff   = {1'b0, duty_q} - {1'b0, tgt_q};
    assign tgt_ready = ready_q;
    assign busy      = busy_q;
    assign duty_out  = duty_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (tgt_valid) begin
                    tgt_q <= tgt_d;
                    if (tgt_d != duty_q) begin
                        state_q <= (tgt_d > duty_q) ? RAMP_UP : RAMP_DOWN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_UP: if (period_tick) begin
                    if (up_diff > {1'b0, STEP_N}) begin
                        duty_q <= duty_q + STEP_N;
                    end else begin
                        duty_q  <= tgt_q;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RAMP_DOWN: if (period_tick) begin
                    if (dn_diff > {1'b0, STEP_N}) begin
                        duty_q <= duty_q - STEP_N;
                    end else begin
                        duty_q  <= tgt_q;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed checks of reset, tick timing, ramp up/down, equal target, async reset and saturation.
module tb_pwm_duty_ramp;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] t1 = '0, t4 = '0, t16 = '0;
    logic       v1 = 1'b0, v4 = 1'b0, v16 = 1'b0;
    logic [7:0] d1, d4, d16;
    logic       r1, r4, r16, k1, k4, k16, b1, b4, b16;
    int         total = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.PERIOD_CYCLES(16), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .tgt_duty(t1), .tgt_valid(v1), .tgt_ready(r1),
        .duty_out(d1), .period_tick(k1), .busy(b1));
    pwm_duty_ramp #(.PERIOD_CYCLES(16), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .tgt_duty(t4), .tgt_valid(v4), .tgt_ready(r4),
        .duty_out(d4), .period_tick(k4), .busy(b4));
    pwm_duty_ramp #(.PERIOD_CYCLES(16), .STEP(16)) u16 (
        .clk(clk), .rst(rst), .tgt_duty(t16), .tgt_valid(v16), .tgt_ready(r16),
        .duty_out(d16), .period_tick(k16), .busy(b16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // advance to the edge that consumes the next period_tick, then sample just after it
    task automatic next_period;
        int n = 0;
        while (k1 !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk("tick_timeout", 32'(n < 40), 32'd1);
        step(1);
    endtask

    initial begin
        int first = 0;
        int exp;
        #12;
        chk("rst_duty", 32'(d1), 0);
        chk("rst_busy", 32'(b1), 0);
        chk("rst_ready", 32'(r1), 1);
        chk("rst_tick", 32'(k1), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            step(1);
            if (k1) first = i;
        end
        chk("first_tick_edge", 32'(first), 15);
        step(1);
        chk("tick_one_cycle", 32'(k1), 0);
        step(15);
        chk("tick_period", 32'(k1), 1);
        // transfer on the tick edge itself: that tick must not move duty
        t1 = 8'd5; v1 = 1'b1; t4 = 8'd10; v4 = 1'b1;
        step(1);
        v1 = 1'b0; v4 = 1'b0;
        chk("up_ready_fall", 32'(r1), 0);
        chk("up_busy_rise", 32'(b1), 1);
        chk("up_no_tick_use", 32'(d1), 0);
        for (int k = 1; k <= 5; k++) begin
            next_period();
            chk("up_duty", 32'(d1), 32'(k));
            chk("up10_s4", 32'(d4), (k == 1) ? 4 : (k == 2) ? 8 : 10);
            if (k == 1) begin
                step(8);
                chk("up_hold_mid", 32'(d1), 1);
            end
        end
        chk("up_done_ready", 32'(r1), 1);
        chk("up_done_busy", 32'(b1), 0);
        chk("s4_idle", 32'(b4), 0);
        t4 = 8'd3; v4 = 1'b1;
        step(1);
        v4 = 1'b0;
        chk("dn_busy", 32'(b4), 1);
        next_period();
        chk("dn_tick1", 32'(d4), 6);
        step(4);
        chk("dn_ready_low", 32'(r4), 0);
        t4 = 8'd99; v4 = 1'b1;
        step(1);
        v4 = 1'b0;
        chk("dn_ignore", 32'(d4), 6);
        next_period();
        chk("dn_tick2", 32'(d4), 3);
        chk("dn_idle", 32'(b4), 0);
        chk("dn_ready", 32'(r4), 1);
        next_period();
        chk("dn_not_queued", 32'(d4), 3);
        t1 = 8'd5; v1 = 1'b1;
        step(1);
        v1 = 1'b0;
        chk("eq_busy", 32'(b1), 0);
        chk("eq_ready", 32'(r1), 1);
        for (int k = 0; k < 3; k++) next_period();
        chk("eq_duty", 32'(d1), 5);
        chk("eq_busy_end", 32'(b1), 0);
        // bring u1 back to 0 before the mid-ramp reset scenario
        t1 = 8'd0; v1 = 1'b1;
        step(1);
        v1 = 1'b0;
        for (int k = 0; k < 5; k++) next_period();
        chk("back_to_zero", 32'(d1), 0);
        t1 = 8'd200; v1 = 1'b1;
        step(1);
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) next_period();
        chk("mr_duty3", 32'(d1), 3);
        step(5);
        #2 rst = 1'b0;
        #1;
        chk("mr_async_duty", 32'(d1), 0);
        chk("mr_async_busy", 32'(b1), 0);
        chk("mr_async_ready", 32'(r1), 1);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        chk("mr_rel_ready", 32'(r1), 1);
        chk("mr_rel_busy", 32'(b1), 0);
        chk("mr_rel_duty", 32'(d1), 0);
        t16 = 8'd255; v16 = 1'b1;
        step(1);
        v16 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            next_period();
`ifdef PWM_DUTY_CLAMP_EN
            exp = (16 * k > 240) ? 240 : 16 * k;
`else
            exp = (16 * k > 255) ? 255 : 16 * k;
`endif
            chk("sat_duty", 32'(d16), 32'(exp));
        end
        chk("sat_idle", 32'(b16), 0);
        next_period();
`ifdef PWM_DUTY_CLAMP_EN
        chk("sat_no_wrap", 32'(d16), 240);
`else
        chk("sat_no_wrap", 32'(d16), 255);
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream stage of the 12-bit-counter PWM generator. Drives that generator's 8-bit compare/duty input.
- Accepts a target duty over a valid/ready handshake.
- Slews the applied duty toward the target by STEP once per PWM period. Updates happen only at period boundaries, so the PWM output never sees a mid-period compare change or a large jump.

Parameters:
- DW, 8, duty width; matches the PWM compare width.
- PERIOD_CYCLES, 4096, clocks per PWM period; matches the 12-bit PWM counter wrap.
- STEP, 1, duty increment/decrement applied per period while ramping (1..2^DW-1).
- MAX_DUTY, 240, upper duty limit; used only when PWM_DUTY_CLAMP_EN is defined.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, reset: asynchronous, active-low.
- tgt_duty, in, DW, requested target duty.
- tgt_valid, in, 1, tgt_duty is valid this cycle.
- tgt_ready, out, 1, block accepts a target this cycle.
- duty_out, out, DW, applied duty; wired to the PWM compare input.
- period_tick, out, 1, one-cycle pulse on the last clock of each PWM period.
- busy, out, 1, ramp in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: duty_out=0, period_tick=0, busy=0, tgt_ready=1.
  - Internal: target register=0, period counter=0, state=IDLE.
  - Takes effect immediately, including mid-ramp.
- Period counter:
  - ceil(log2(PERIOD_CYCLES))-bit counter, counts 0..PERIOD_CYCLES-1 and wraps to 0.
  - period_tick is registered and high for exactly one clock when the counter equals PERIOD_CYCLES-1.
  - Released from reset on the same edge as the PWM block, so boundaries stay aligned.
- Handshake:
  - Transfer occurs when tgt_valid && tgt_ready at a rising edge.
  - tgt_ready = (state==IDLE) and is registered.
  - tgt_valid while tgt_ready=0 is ignored and never queued.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
  - IDLE, on transfer: load target.
    - target > duty_out → RAMP_UP.
    - target < duty_out → RAMP_DOWN.
    - target == duty_out → stay IDLE; tgt_ready stays 1.
  - RAMP_UP, on period_tick:
    - If target - duty_out > STEP: duty_out += STEP.
    - Otherwise: duty_out = target, go to IDLE.
  - RAMP_DOWN, on period_tick: same rule mirrored (subtract STEP, snap to target, go to IDLE).
  - RAMP states without period_tick: hold duty_out.
- busy = (state != IDLE), registered.
- Latency:
  - tgt_ready falls and busy rises one clock after the transfer.
  - The first duty change lands on the first period_tick after the transfer edge.
  - If the transfer edge coincides with period_tick, that tick is not used; the next one is.
- Arithmetic:
  - Compare and difference in DW+1 bits.
  - duty_out never overshoots the target and never wraps: 255 + STEP does not become a small value; 0 - STEP does not become a large value.
- duty_out changes only on the clock edge where period_tick is high. It is therefore stable for the whole following period.

Optional Feature:
- Macro: PWM_DUTY_CLAMP_EN.
- Defined: an accepted tgt_duty > MAX_DUTY is stored as MAX_DUTY. The FSM then compares against the clamped value, so duty_out ≤ MAX_DUTY always.
- Undefined: the full 0..2^DW-1 range is accepted unmodified, and the MAX_DUTY parameter is unused.

Decomposition:
- Shared package pwm_pkg: DW default, PERIOD_CYCLES default, the state encoding (IDLE/RAMP_UP/RAMP_DOWN), and MAX_DUTY default.
- One natural sub-module: pwm_period_tick (period counter plus period_tick pulse). It can be reused by other PWM-side stages.

Test Plan:
Bench settings: PERIOD_CYCLES=16, STEP=1 unless stated otherwise.
- Reset: hold rst low, then release → duty_out=0, busy=0, tgt_ready=1; period_tick first high on clock 16 after release, then every 16 clocks.
- Ramp up: from 0, send tgt_duty=5 → tgt_ready=0 and busy=1 next clock; duty_out steps 1,2,3,4,5 on 5 consecutive ticks; after the 5th, IDLE, tgt_ready=1.
- Ramp down, STEP=4: duty_out=10, send 3 → 6 on tick 1, 3 on tick 2 (no undershoot); then IDLE. A tgt_valid pulse with value 99 during the ramp is ignored.
- Equal target: duty_out=5, send 5 → no state change, busy stays 0, tgt_ready stays 1, duty_out stays 5 across 3 periods.
- Reset mid-ramp: ramping 0→200, at duty_out=3 pull rst low mid-period → duty_out=0 and busy=0 the same cycle, without a clock edge; after release, IDLE and tgt_ready=1.
- Clamp/saturation, STEP=16, send 255:
  - With PWM_DUTY_CLAMP_EN: stops at 240.
  - Without it: sequence ends 240→255, never wraps to 0.
